// File: rtl/gate_response_checker.sv
// gate_response_checker: drives the four (a,b) vectors into a gate block,
// compares and/or/not responses against the ideal gates and reports a verdict.
module gate_response_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_PASSES    = 1,
  parameter int unsigned ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             and_out,
  input  logic             or_out,
  input  logic             not_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       err_vec
);

  // A zero settle time still needs one sampling cycle; zero passes means one.
  localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam int unsigned PASSES_EFF = (NUM_PASSES == 0) ? 1 : NUM_PASSES;
  localparam int unsigned CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
  localparam int unsigned PASS_W     = (PASSES_EFF > 1) ? $clog2(PASSES_EFF) : 1;

  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SETTLE_EFF - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES_EFF - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         idx, idx_nxt;
  logic [PASS_W-1:0]  pass_idx, pass_idx_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               a_nxt, b_nxt;
  logic               busy_nxt, done_nxt, pass_nxt;
  logic [ERR_W-1:0]   err_count_nxt;
  logic [2:0]         err_vec_nxt;
  logic [2:0]         mismatch_c;

  // Per-output disagreement with the ideal gates for the vector on a/b.
  always_comb begin
    mismatch_c[0] = and_out ^ (a & b);
    mismatch_c[1] = or_out  ^ (a | b);
    mismatch_c[2] = not_out ^ (~a);
  end

  // Next-state and next-output logic; every register holds unless updated.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    pass_idx_nxt  = pass_idx;
    cnt_nxt       = cnt;
    a_nxt         = a;
    b_nxt         = b;
    pass_nxt      = pass;
    err_count_nxt = err_count;
    err_vec_nxt   = err_vec;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = DRIVE;
          idx_nxt       = 2'd0;
          pass_idx_nxt  = '0;
          err_count_nxt = '0;
          err_vec_nxt   = 3'b000;
          pass_nxt      = 1'b0;
        end
      end
      DRIVE: begin
        state_nxt = SETTLE;
        cnt_nxt   = CNT_LOAD;
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_nxt = CHECK;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      CHECK: begin
        if (mismatch_c != 3'b000) begin
          err_vec_nxt = err_vec | mismatch_c;
          if (err_count != ERR_MAX) begin
            err_count_nxt = err_count + ERR_W'(1);
          end
        end
        if (idx != 2'd3) begin
          state_nxt = DRIVE;
          idx_nxt   = idx + 2'd1;
        end else if (pass_idx != PASS_LAST) begin
          state_nxt    = DRIVE;
          idx_nxt      = 2'd0;
          pass_idx_nxt = pass_idx + PASS_W'(1);
        end else begin
          state_nxt = DONE;
          pass_nxt  = (err_count_nxt == '0);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // DRIVE is always a one-cycle state, so entering it is the only time a/b move.
    if (state_nxt == DRIVE) begin
      a_nxt = idx_nxt[1];
      b_nxt = idx_nxt[0];
    end
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 2'd0;
      pass_idx  <= '0;
      cnt       <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      err_vec   <= 3'b000;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      pass_idx  <= pass_idx_nxt;
      cnt       <= cnt_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      err_count <= err_count_nxt;
      err_vec   <= err_vec_nxt;
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench for gate_response_checker: four instances with different
// parameters, each driving a gate model with a selectable fault.
module tb_gate_response_checker;

  typedef struct {
    int lat;
    int errc;
    int errv;
    int pss;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] start;
  logic [3:0] a_o, b_o, busy_o, done_o, pass_o;
  logic [3:0] and_i, or_i, not_i;
  logic [3:0] errc_o [4];
  logic [1:0] errc2;
  logic [2:0] errv_o [4];
  int         fault  [4];
  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  // Gate block under test; fault 1: and stuck 0, 2: not = a, 3: or stuck 1.
  function automatic logic [2:0] gate_model(input int f, input logic ga, input logic gb);
    logic g_and, g_or, g_not;
    g_and = ga & gb;
    g_or  = ga | gb;
    g_not = ~ga;
    if (f == 1) g_and = 1'b0;
    if (f == 2) g_not = ga;
    if (f == 3) g_or  = 1'b1;
    return {g_not, g_or, g_and};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_gates
    assign {not_i[g], or_i[g], and_i[g]} = gate_model(fault[g], a_o[g], b_o[g]);
  end

  assign errc_o[2] = {2'b00, errc2};

  gate_response_checker u_def (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a_o[0]), .b(b_o[0]),
    .and_out(and_i[0]), .or_out(or_i[0]), .not_out(not_i[0]),
    .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
    .err_count(errc_o[0]), .err_vec(errv_o[0]));

  gate_response_checker #(.NUM_PASSES(2)) u_np2 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a_o[1]), .b(b_o[1]),
    .and_out(and_i[1]), .or_out(or_i[1]), .not_out(not_i[1]),
    .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
    .err_count(errc_o[1]), .err_vec(errv_o[1]));

  gate_response_checker #(.NUM_PASSES(2), .ERR_W(2)) u_np2_e2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .a(a_o[2]), .b(b_o[2]),
    .and_out(and_i[2]), .or_out(or_i[2]), .not_out(not_i[2]),
    .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]),
    .err_count(errc2), .err_vec(errv_o[2]));

  gate_response_checker #(.SETTLE_CYCLES(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .a(a_o[3]), .b(b_o[3]),
    .and_out(and_i[3]), .or_out(or_i[3]), .not_out(not_i[3]),
    .busy(busy_o[3]), .done(done_o[3]), .pass(pass_o[3]),
    .err_count(errc_o[3]), .err_vec(errv_o[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference verdict: golden gates vs the faulty gate model over every vector.
  task automatic model(input int f, input int np, input int errmax, output exp_t e);
    logic [2:0] d;
    logic [1:0] v;
    e.errc = 0;
    e.errv = 0;
    for (int p = 0; p < np; p++) begin
      for (int i = 0; i < 4; i++) begin
        v = 2'(i);
        d = gate_model(f, v[1], v[0]) ^ {~v[1], v[1] | v[0], v[1] & v[0]};
        if (d != 3'b000) begin
          if (e.errc < errmax) e.errc++;
          e.errv = e.errv | int'(d);
        end
      end
    end
    e.pss = (e.errc == 0) ? 1 : 0;
  endtask

  task automatic check_zero(input int k, input string tag);
    check({tag, "_a"},    a_o[k],    0);
    check({tag, "_b"},    b_o[k],    0);
    check({tag, "_busy"}, busy_o[k], 0);
    check({tag, "_done"}, done_o[k], 0);
    check({tag, "_pass"}, pass_o[k], 0);
    check({tag, "_errc"}, errc_o[k], 0);
    check({tag, "_errv"}, errv_o[k], 0);
  endtask

  // One run on instance k; optionally pulses start mid-run (must be ignored).
  task automatic run(input int k, input int s_eff, input int np, input int errmax,
                     input bit poke_mid);
    exp_t e;
    int   c;
    model(fault[k], np, errmax, e);
    e.lat = np * 4 * (s_eff + 2);
    sb.push_back(e);
    @(negedge clk) start[k] = 1'b1;
    @(posedge clk);
    #1 start[k] = 1'b0;
    c = 0;
    while (!done_o[k] && c <= e.lat + 4) begin
      if (c < e.lat) begin
        check("ab_seq", {a_o[k], b_o[k]}, (c / (s_eff + 2)) % 4);
        check("busy_run", busy_o[k], 1);
      end
      start[k] = (poke_mid && c == 5);
      @(posedge clk);
      #1 c++;
    end
    start[k] = 1'b0;
    e = sb.pop_front();
    if (!done_o[k]) begin
      check("done_timeout", 0, 1);
      return;
    end
    check("latency",  c,         e.lat);
    check("errc",     errc_o[k], e.errc);
    check("errv",     errv_o[k], e.errv);
    check("pass",     pass_o[k], e.pss);
    check("busy_done", busy_o[k], 1);
    @(posedge clk);
    #1;
    check("done_pulse", done_o[k], 0);
    check("busy_idle",  busy_o[k], 0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_busy", busy_o[k], 0);
    check("hold_errc", errc_o[k], e.errc);
    check("hold_errv", errv_o[k], e.errv);
    check("hold_pass", pass_o[k], e.pss);
  endtask

  initial begin
    int c, d1, d2, idle, pulses;
    rst_n = 1'b0;
    start = 4'b0000;
    for (int k = 0; k < 4; k++) fault[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) check_zero(k, "rst");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Golden gates, faulty and, missing inversion (x2 passes, saturating), stuck or.
    run(0, 2, 1, 15, 1'b0);
    fault[0] = 1;
    run(0, 2, 1, 15, 1'b0);
    fault[1] = 2;
    run(1, 2, 2, 15, 1'b0);
    fault[2] = 2;
    run(2, 2, 2, 3, 1'b0);
    fault[3] = 3;
    run(3, 1, 1, 15, 1'b0);
    fault[0] = 0;
    run(0, 2, 1, 15, 1'b1);

    // Start held high: back-to-back runs with one IDLE cycle in between.
    @(negedge clk) start[0] = 1'b1;
    @(posedge clk);
    #1 c = 0;
    d1 = -1;
    d2 = -1;
    idle = 0;
    while (d2 < 0 && c < 60) begin
      if (done_o[0]) begin
        if (d1 < 0) d1 = c;
        else d2 = c;
      end
      if (d1 >= 0 && d2 < 0 && !busy_o[0]) idle++;
      @(posedge clk);
      #1 c++;
    end
    start[0] = 1'b0;
    check("held_done1", d1, 16);
    check("held_done2", d2, 34);
    check("held_idle",  idle, 1);
    repeat (4) @(posedge clk);
    #1 check("held_stop", busy_o[0], 0);

    // Reset during settle of vector 2 aborts with no done pulse.
    @(negedge clk) start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1 check("pre_rst_ab", {a_o[0], b_o[0]}, 2);
    #2 rst_n = 1'b0;
    #1 check_zero(0, "mid_rst");
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 if (done_o[0] || busy_o[0]) pulses++;
    end
    check("no_done_after_rst", pulses, 0);
    run(0, 2, 1, 15, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
